fifo_sram_prefetch: RTL and testbench

//  Parametrised SRAM-backed FIFO with a first-word-fall-through (FWFT) output.
//  - Storage is a simple dual-port array with configurable read latency RD_LATENCY.
//  - A credit-controlled prefetch buffer hides that latency, so data_o is valid whenever empty_o=0.
//  - Drop-in successor to the single/dual-port SRAM FIFOs; the DFF FIFO remains the golden model.

---
 rtl/fifo_sram_prefetch.sv | 180 ++++++++++++++++++
 tb/tb_fifo_sram_prefetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sram_prefetch.sv
// SRAM-backed FIFO with first-word-fall-through output; a credit-controlled prefetch buffer hides SRAM read latency.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_sram_prefetch #(
    parameter int WIDTH            = 10,
    parameter int DEPTH            = 10,
    parameter int RD_LATENCY       = 1,
    parameter int ALMOST_FULL_LVL  = DEPTH - 2,
    parameter int ALMOST_EMPTY_LVL = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [1:0]                 err_o
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int NBUF = RD_LATENCY + 1;
    localparam int BW   = $clog2(NBUF);
    localparam int BCW  = $clog2(NBUF + 1);

    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_C     = CW'(ALMOST_FULL_LVL);
    localparam logic [CW-1:0]  AE_C     = CW'(ALMOST_EMPTY_LVL);
    localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH - 1);
    localparam logic [BW-1:0]  BUF_LAST = BW'(NBUF - 1);
    localparam logic [BCW-1:0] NBUF_C   = BCW'(NBUF);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    sram_cnt;
    logic [CW-1:0]    count_q;

    logic [RD_LATENCY-1:0] pipe_vld;
    logic [WIDTH-1:0]      pipe_data [RD_LATENCY];

    logic [WIDTH-1:0] buf_mem [NBUF];
    logic [BW-1:0]    buf_rd;
    logic [BW-1:0]    buf_wr;
    logic [BCW-1:0]   buf_cnt;
    logic [BCW-1:0]   credits;

    logic push;
    logic pop;
    logic issue;
    logic fill;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] p);
        return (p == BUF_LAST) ? '0 : p + BW'(1);
    endfunction

    assign pop  = rd_en_i && !empty_o;
    assign push = wr_en_i && (!full_o || pop);
    // A pop frees its slot at this edge, so its credit can fund a read issued in the same cycle.
    assign issue = (sram_cnt != '0) && ((credits != '0) || pop);
    assign fill  = pipe_vld[RD_LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (issue) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, issue})
                2'b10:   sram_cnt <= sram_cnt + CW'(1);
                2'b01:   sram_cnt <= sram_cnt - CW'(1);
                default: sram_cnt <= sram_cnt;
            endcase
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Read pipeline models the SRAM latency; stage 0 captures the array output at the issue edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            if (issue) begin
                pipe_data[0] <= mem[rd_ptr];
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_rd  <= '0;
            buf_wr  <= '0;
            buf_cnt <= '0;
            credits <= NBUF_C;
            for (int i = 0; i < NBUF; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            if (fill) begin
                buf_mem[buf_wr] <= pipe_data[RD_LATENCY-1];
                buf_wr          <= buf_inc(buf_wr);
            end
            if (pop) begin
                buf_rd <= buf_inc(buf_rd);
            end
            unique case ({fill, pop})
                2'b10:   buf_cnt <= buf_cnt + BCW'(1);
                2'b01:   buf_cnt <= buf_cnt - BCW'(1);
                default: buf_cnt <= buf_cnt;
            endcase
            unique case ({issue, pop})
                2'b10:   credits <= credits - BCW'(1);
                2'b01:   credits <= credits + BCW'(1);
                default: credits <= credits;
            endcase
        end
    end

    assign data_o         = buf_mem[buf_rd];
    assign empty_o        = (buf_cnt == '0);
    assign full_o         = (count_q == DEPTH_C);
    assign almost_full_o  = (count_q >= AF_C);
    assign almost_empty_o = (count_q <= AE_C);
    assign count_o        = count_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic [1:0] err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 2'b00;
        end else begin
            if (wr_en_i && full_o && !pop) begin
                err_q[0] <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 2'b00;
`endif

endmodule

// File: tb/tb_fifo_sram_prefetch.sv
// Directed bench for fifo_sram_prefetch: a default instance (RD_LATENCY=1) and a RD_LATENCY=2 instance share stimulus.
module tb_fifo_sram_prefetch;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wr_en;
    logic       rd_en;
    logic [9:0] din;

    logic [9:0] d_data;
    logic       d_empty, d_full, d_af, d_ae;
    logic [3:0] d_count;
    logic [1:0] d_err;

    logic [9:0] e_data;
    logic       e_empty, e_full, e_af, e_ae;
    logic [3:0] e_count;
    logic [1:0] e_err;

    int n_total = 0;
    int n_pass  = 0;

`ifdef FIFO_ERR_FLAGS_EN
    localparam logic [1:0] ERR_UF  = 2'b10;
    localparam logic [1:0] ERR_ALL = 2'b11;
`else
    localparam logic [1:0] ERR_UF  = 2'b00;
    localparam logic [1:0] ERR_ALL = 2'b00;
`endif

    fifo_sram_prefetch #(.WIDTH(10), .DEPTH(10), .RD_LATENCY(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
        .data_o(d_data), .empty_o(d_empty), .full_o(d_full), .almost_full_o(d_af),
        .almost_empty_o(d_ae), .count_o(d_count), .err_o(d_err)
    );

    fifo_sram_prefetch #(.WIDTH(10), .DEPTH(10), .RD_LATENCY(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
        .data_o(e_data), .empty_o(e_empty), .full_o(e_full), .almost_full_o(e_af),
        .almost_empty_o(e_ae), .count_o(e_count), .err_o(e_err)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [9:0] din;
        logic [3:0] cnt;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       chk_data;
        logic [9:0] dout;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Pops whenever the default instance shows a word; expects base, base+1, ... for n words.
    task automatic drain(input int base, input int n);
        int idx;
        idx = 0;
        wr_en = 1'b0;
        for (int c = 0; c < 60 && idx < n; c++) begin
            if (!d_empty) begin
                chk("drain_data", d_data, base + idx);
                rd_en = 1'b1;
                idx++;
            end else begin
                rd_en = 1'b0;
            end
            step();
        end
        rd_en = 1'b0;
        chk("drain_len", idx, n);
        chk("drain_count", d_count, 0);
        chk("drain_empty", d_empty, 1);
    endtask

    initial begin
        logic [9:0] model[$];
        int seen;
        int stale;

        vecs[0] = '{1'b1, 1'b0, 10'h011, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
        vecs[1] = '{1'b1, 1'b0, 10'h022, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
        vecs[2] = '{1'b0, 1'b0, 10'h000, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h011};
        vecs[3] = '{1'b1, 1'b0, 10'h033, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h011};
        vecs[4] = '{1'b0, 1'b1, 10'h000, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h022};
        vecs[5] = '{1'b1, 1'b1, 10'h044, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h033};
        vecs[6] = '{1'b0, 1'b1, 10'h000, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
        vecs[7] = '{1'b0, 1'b0, 10'h000, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h044};
        vecs[8] = '{1'b0, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};
        vecs[9] = '{1'b0, 1'b1, 10'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000};

        // Reset values after idling.
        do_reset();
        repeat (5) step();
        chk("rst_empty", d_empty, 1);
        chk("rst_count", d_count, 0);
        chk("rst_full", d_full, 0);
        chk("rst_almost_empty", d_ae, 1);
        chk("rst_almost_full", d_af, 0);
        chk("rst_err", d_err, 0);
        chk("rst_data", d_data, 0);
        chk("rst_empty_l2", e_empty, 1);

        // Vector table on the default instance.
        for (int i = 0; i < 10; i++) begin
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            din   = vecs[i].din;
            step();
            chk($sformatf("vec%0d_count", i), d_count, vecs[i].cnt);
            chk($sformatf("vec%0d_empty", i), d_empty, vecs[i].empty);
            chk($sformatf("vec%0d_full", i), d_full, vecs[i].full);
            chk($sformatf("vec%0d_almost_empty", i), d_ae, vecs[i].ae);
            chk($sformatf("vec%0d_almost_full", i), d_af, vecs[i].af);
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_data", i), d_data, vecs[i].dout);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Latency: RD_LATENCY=2 shows the word three edges after the push.
        do_reset();
        wr_en = 1'b1;
        din   = 10'h155;
        step();
        wr_en = 1'b0;
        chk("lat_count", e_count, 1);
        chk("lat_empty_e0", e_empty, 1);
        step();
        chk("lat_empty_e1", e_empty, 1);
        step();
        chk("lat_empty_e2", e_empty, 1);
        chk("lat_l1_empty_e2", d_empty, 0);
        chk("lat_l1_data_e2", d_data, 10'h155);
        step();
        chk("lat_empty_e3", e_empty, 0);
        chk("lat_data_e3", e_data, 10'h155);

        // Fill to full, push+pop at full, drain.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            wr_en = 1'b1;
            din   = 10'(k);
            step();
            chk($sformatf("fill%0d_count", k), d_count, k);
            chk($sformatf("fill%0d_almost_full", k), d_af, (k >= 8) ? 1 : 0);
            chk($sformatf("fill%0d_full", k), d_full, (k == 10) ? 1 : 0);
        end
        chk("full_head", d_data, 1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 10'd11;
        step();
        chk("full_pp_count", d_count, 10);
        chk("full_pp_full", d_full, 1);
        chk("full_pp_head", d_data, 2);
        drain(2, 10);

        // Steady state: 3-word prime, then 25 push+pop pairs with no bubble.
        do_reset();
        model.delete();
        for (int k = 0; k < 3; k++) begin
            wr_en = 1'b1;
            din   = 10'h100 + 10'(k);
            model.push_back(din);
            step();
        end
        wr_en = 1'b0;
        repeat (2) step();
        for (int k = 0; k < 25; k++) begin
            chk("steady_empty", d_empty, 0);
            chk("steady_data", d_data, model[0]);
            void'(model.pop_front());
            wr_en = 1'b1;
            rd_en = 1'b1;
            din   = 10'h200 + 10'(k);
            model.push_back(din);
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("steady_count", d_count, 3);
        drain(10'h200 + 22, 3);

        // Asynchronous reset with two reads in flight in the RD_LATENCY=2 instance.
        do_reset();
        wr_en = 1'b1;
        din   = 10'h0C1;
        step();
        din   = 10'h0C2;
        step();
        wr_en = 1'b0;
        step();
        chk("inflight_empty", e_empty, 1);
        chk("inflight_count", e_count, 2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_empty_l2", e_empty, 1);
        chk("async_rst_count_l2", e_count, 0);
        chk("async_rst_empty", d_empty, 1);
        chk("async_rst_count", d_count, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wr_en = 1'b1;
        din   = 10'h03A;
        step();
        wr_en = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            if (!e_empty) begin
                seen = 1;
                chk("post_rst_first", e_data, 10'h03A);
                rd_en = 1'b1;
            end
            step();
        end
        rd_en = 1'b0;
        chk("post_rst_seen", seen, 1);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (!e_empty) stale++;
            step();
        end
        chk("post_rst_no_stale", stale, 0);
        chk("post_rst_count", e_count, 0);

        // Error flags: underflow, then overflow; contents untouched.
        do_reset();
        step();
        chk("err_initial", d_err, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("err_underflow", d_err, ERR_UF);
        chk("err_underflow_count", d_count, 0);
        for (int k = 0; k < 10; k++) begin
            wr_en = 1'b1;
            din   = 10'h0A0 + 10'(k);
            step();
        end
        chk("err_before_ovf", d_err, ERR_UF);
        wr_en = 1'b1;
        din   = 10'h3FF;
        step();
        wr_en = 1'b0;
        chk("err_overflow", d_err, ERR_ALL);
        chk("err_ovf_count", d_count, 10);
        repeat (2) step();
        chk("err_hold", d_err, ERR_ALL);
        chk("err_head", d_data, 10'h0A0);
        drain(10'h0A0, 10);
        chk("err_hold_after_drain", d_err, ERR_ALL);
        do_reset();
        step();
        chk("err_cleared", d_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
